// File: rtl/atax_pkg.sv
`default_nettype none
// ============================================================================
// Module  : atax_pkg
// Brief   : Shared sizes and FSM state encoding for the ATAX stream loader.
// Revision: 1.0 - initial release
// ============================================================================
package atax_pkg;

    localparam int ATAX_N       = 4;
    localparam int ATAX_DATA_W  = 32;
    localparam int ATAX_VADDR_W = 2;
    localparam int ATAX_MADDR_W = 4;

    // Nine states do not fit in three bits, so the binary form uses four.
    localparam bit ONE_HOT = 1'b0;
    localparam int STATE_W = ONE_HOT ? 9 : 4;

    function automatic logic [STATE_W-1:0] state_code(input int idx);
        return ONE_HOT ? (STATE_W'(1) << idx) : STATE_W'(idx);
    endfunction

    localparam logic [STATE_W-1:0] c_st_idle     = state_code(0);
    localparam logic [STATE_W-1:0] c_st_load_x   = state_code(1);
    localparam logic [STATE_W-1:0] c_st_load_a   = state_code(2);
    localparam logic [STATE_W-1:0] c_st_start    = state_code(3);
    localparam logic [STATE_W-1:0] c_st_wait     = state_code(4);
    localparam logic [STATE_W-1:0] c_st_rd_issue = state_code(5);
    localparam logic [STATE_W-1:0] c_st_rd_wait  = state_code(6);
    localparam logic [STATE_W-1:0] c_st_rd_hold  = state_code(7);
    localparam logic [STATE_W-1:0] c_st_fin      = state_code(8);

endpackage
`default_nettype wire

// File: rtl/atax_stream_loader.sv
`default_nettype none
// ============================================================================
// Module  : atax_stream_loader
// Brief   : Loads x and A into the ATAX kernel RAMs from a word stream, runs
//           the kernel, then drains the y RAM as a word stream.
// Revision: 1.0 - initial release
// ============================================================================
module atax_stream_loader
    import atax_pkg::*;
#(
    parameter int N       = ATAX_N,
    parameter int DATA_W  = ATAX_DATA_W,
    parameter int VADDR_W = ATAX_VADDR_W,
    parameter int MADDR_W = ATAX_MADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    output logic               busy,
    output logic               done,
    input  logic [DATA_W-1:0]  s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [DATA_W-1:0]  m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               k_start,
    input  logic               k_finish,
    output logic               x_we,
    output logic               x_en,
    output logic [VADDR_W-1:0] x_addr,
    output logic [DATA_W-1:0]  x_wdata,
    output logic               a_we,
    output logic               a_en,
    output logic [MADDR_W-1:0] a_addr,
    output logic [DATA_W-1:0]  a_wdata,
    output logic               y_en,
    output logic [VADDR_W-1:0] y_addr,
    input  logic [DATA_W-1:0]  y_rdata
);

    localparam logic [MADDR_W-1:0] c_last_v = MADDR_W'(N - 1);
    localparam logic [MADDR_W-1:0] c_last_a = MADDR_W'(N * N - 1);

    logic [STATE_W-1:0] r_state;
    logic [MADDR_W-1:0] r_cnt;
    logic               r_m_valid;
    logic [DATA_W-1:0]  r_m_data;

    logic w_load_x;
    logic w_load_a;
    logic w_x_wr;
    logic w_a_wr;

    assign w_load_x = (r_state == c_st_load_x);
    assign w_load_a = (r_state == c_st_load_a);
    assign w_x_wr   = w_load_x & s_valid;
    assign w_a_wr   = w_load_a & s_valid;

    // RAM writes follow the stream handshake in the same cycle; the ports
    // are forced to zero whenever no write is happening.
    assign s_ready = w_load_x | w_load_a;
    assign x_en    = w_x_wr;
    assign x_we    = w_x_wr;
    assign x_addr  = w_x_wr ? r_cnt[VADDR_W-1:0] : '0;
    assign x_wdata = w_x_wr ? s_data : '0;
    assign a_en    = w_a_wr;
    assign a_we    = w_a_wr;
    assign a_addr  = w_a_wr ? r_cnt : '0;
    assign a_wdata = w_a_wr ? s_data : '0;

    assign y_en    = (r_state == c_st_rd_issue);
    assign y_addr  = y_en ? r_cnt[VADDR_W-1:0] : '0;
    assign k_start = (r_state == c_st_start);
    assign done    = (r_state == c_st_fin);
    assign busy    = (r_state != c_st_idle);
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_cnt     <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (go) begin
                        r_state <= c_st_load_x;
                        r_cnt   <= '0;
                    end
                end
                c_st_load_x: begin
                    if (s_valid) begin
                        if (r_cnt == c_last_v) begin
                            r_cnt   <= '0;
                            r_state <= c_st_load_a;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                c_st_load_a: begin
                    if (s_valid) begin
                        if (r_cnt == c_last_a) begin
                            r_cnt   <= '0;
                            r_state <= c_st_start;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                c_st_start: begin
                    // k_finish is not looked at here, only from WAIT onward.
                    r_state <= c_st_wait;
                end
                c_st_wait: begin
                    if (k_finish) begin
                        r_cnt   <= '0;
                        r_state <= c_st_rd_issue;
                    end
                end
                c_st_rd_issue: begin
                    r_state <= c_st_rd_wait;
                end
                c_st_rd_wait: begin
                    r_m_data  <= y_rdata;
                    r_m_valid <= 1'b1;
                    r_state   <= c_st_rd_hold;
                end
                c_st_rd_hold: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        if (r_cnt == c_last_v) begin
                            r_cnt   <= '0;
                            r_state <= c_st_fin;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            r_state <= c_st_rd_issue;
                        end
                    end
                end
                c_st_fin: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state   <= c_st_idle;
                    r_cnt     <= '0;
                    r_m_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
